// File: rtl/ps2_kbd_rx_if.sv
// Key-event bus from the PS/2 keyboard receiver toward the HID matrix.
interface ps2_kbd_rx_if;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       frame_err;

  modport master (
    output key_strobe,
    output key_pressed,
    output key_extended,
    output key_code,
    output frame_err
  );

  modport slave (
    input key_strobe,
    input key_pressed,
    input key_extended,
    input key_code,
    input frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions the raw lines, deserialises 11-bit frames
// and folds set-2 E0/F0/E1 prefixes into one key event per key.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 64000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_kbd_rx_if.master kbd
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic             r_flt_clk, r_flt_clk_d;
  logic [7:0]       r_flt_cnt;
  state_t           r_state, w_state_nxt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic             r_parity;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [2:0]       r_pause_cnt;
  logic             r_ext, r_rel;
  logic             r_key_strobe, r_key_pressed, r_key_extended, r_frame_err;
  logic [7:0]       r_key_code;
  logic             w_fall, w_bit, w_accept, w_err;

  assign w_fall = r_flt_clk_d & ~r_flt_clk;
  assign w_bit  = r_dat_s2;

  // Synchronisers and glitch filter on the PS/2 clock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_flt_clk   <= 1'b1;
      r_flt_clk_d <= 1'b1;
      r_flt_cnt   <= '0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_flt_clk_d <= r_flt_clk;
      if (r_clk_s2 != r_flt_clk) begin
        if (r_flt_cnt == 8'(FILTER_LEN - 1)) begin
          r_flt_clk <= r_clk_s2;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + 8'd1;
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A fall on the expiry cycle restarts the timer, so timeout only fires without one
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err       = 1'b0;
    if (r_state != S_IDLE && !w_fall && r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
      w_err       = 1'b1;
      w_state_nxt = S_IDLE;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!w_bit) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          if (w_bit && (^{r_shift, r_parity})) w_accept = 1'b1;
          else                                  w_err    = 1'b1;
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      if (w_fall || r_state == S_IDLE || w_state_nxt == S_IDLE) r_tmo_cnt <= '0;
      else                                                       r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      if (w_fall) begin
        case (r_state)
          S_IDLE: r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_parity <= w_bit;
          default: ;
        endcase
      end
    end
  end

  // Byte decoder: prefix tracking, Pause swallowing and key event generation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pause_cnt    <= '0;
      r_ext          <= 1'b0;
      r_rel          <= 1'b0;
      r_key_strobe   <= 1'b0;
      r_key_pressed  <= 1'b0;
      r_key_extended <= 1'b0;
      r_key_code     <= '0;
      r_frame_err    <= 1'b0;
    end else begin
      r_key_strobe <= 1'b0;
      r_frame_err  <= w_err;
      if (w_accept) begin
        if (r_pause_cnt != 3'd0) begin
          r_pause_cnt <= r_pause_cnt - 3'd1;
        end else begin
          case (r_shift)
            8'hE1: begin
              r_pause_cnt <= 3'd7;
              r_ext       <= 1'b0;
              r_rel       <= 1'b0;
            end
            8'hE0: r_ext <= 1'b1;
            8'hF0: r_rel <= 1'b1;
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: begin
              r_ext <= 1'b0;
              r_rel <= 1'b0;
            end
            default: begin
              r_key_code     <= r_shift;
              r_key_pressed  <= ~r_rel;
              r_key_extended <= r_ext;
              r_key_strobe   <= 1'b1;
              r_ext          <= 1'b0;
              r_rel          <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign kbd.key_strobe   = r_key_strobe;
  assign kbd.key_pressed  = r_key_pressed;
  assign kbd.key_extended = r_key_extended;
  assign kbd.key_code     = r_key_code;
  assign kbd.frame_err    = r_frame_err;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: clean frames, prefixes, errors, glitch, timeout, Pause, reset.
module tb_ps2_kbd_rx;

  localparam int unsigned FL = 4;
  localparam int unsigned TO = 300;
  localparam int          H  = 20;

  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_str = 0, n_ferr = 0, n_dbl = 0;
  logic prev_s = 1'b0, prev_e = 1'b0;
  int   s0, e0;

  ps2_kbd_rx_if kbd ();

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd.master)
  );

  always #5 clk = ~clk;

  // Event counters sampled away from the active edge
  always @(negedge clk) begin
    if (kbd.key_strobe) n_str++;
    if (kbd.frame_err)  n_ferr++;
    if ((kbd.key_strobe && prev_s) || (kbd.frame_err && prev_e)) n_dbl++;
    prev_s = kbd.key_strobe;
    prev_e = kbd.frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    repeat (H) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      repeat (FL - 1) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_bit);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == glitch_bit);
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par);
    logic par;
    par = ~(^d) ^ bad_par;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d);
    send_bits(mk_frame(d, 1'b0), 11, -1);
  endtask

  task automatic mark;
    s0 = n_str;
    e0 = n_ferr;
  endtask

  task automatic check_key(input string tag, input logic [7:0] code, input logic pr, input logic ex);
    check_eq({tag, "_strobes"}, 32'(n_str - s0), 32'd1);
    check_eq({tag, "_errs"}, 32'(n_ferr - e0), 32'd0);
    check_eq({tag, "_code"}, 32'(kbd.key_code), 32'(code));
    check_eq({tag, "_pressed"}, 32'(kbd.key_pressed), 32'(pr));
    check_eq({tag, "_ext"}, 32'(kbd.key_extended), 32'(ex));
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_strobe", 32'(kbd.key_strobe), 32'd0);
    check_eq("rst_err", 32'(kbd.frame_err), 32'd0);
    check_eq("rst_code", 32'(kbd.key_code), 32'd0);
    check_eq("rst_pressed", 32'(kbd.key_pressed), 32'd0);
    check_eq("rst_ext", 32'(kbd.key_extended), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Clean make of A
    mark(); send_byte(8'h1C);
    check_key("make_1c", 8'h1C, 1'b1, 1'b0);

    // Extended release of Up, then plain make
    mark(); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_key("rel_up", 8'h75, 1'b0, 1'b1);
    mark(); send_byte(8'h1C);
    check_key("after_up", 8'h1C, 1'b1, 1'b0);

    // Parity error drops the byte; following F0 1C is a release
    mark(); send_bits(mk_frame(8'h1C, 1'b1), 11, -1);
    check_eq("par_err_errs", 32'(n_ferr - e0), 32'd1);
    check_eq("par_err_strobes", 32'(n_str - s0), 32'd0);
    mark(); send_byte(8'hF0); send_byte(8'h1C);
    check_key("rel_1c", 8'h1C, 1'b0, 1'b0);

    // Short clock glitch mid-frame must not shift an extra bit
    mark(); send_bits(mk_frame(8'h2A, 1'b0), 11, 3);
    check_key("glitch", 8'h2A, 1'b1, 1'b0);
    mark(); send_byte(8'h1C);
    check_key("post_glitch", 8'h1C, 1'b1, 1'b0);

    // Stall after 4 data bits: timeout error, then recovery
    mark(); send_bits(mk_frame(8'h1C, 1'b0), 5, -1);
    repeat (TO + 10) @(negedge clk);
    check_eq("tmo_errs", 32'(n_ferr - e0), 32'd1);
    check_eq("tmo_strobes", 32'(n_str - s0), 32'd0);
    mark(); send_byte(8'h1C);
    check_key("post_tmo", 8'h1C, 1'b1, 1'b0);

    // Pause sequence is swallowed, next key decodes
    mark();
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
    check_eq("pause_strobes", 32'(n_str - s0), 32'd0);
    check_eq("pause_errs", 32'(n_ferr - e0), 32'd0);
    mark(); send_byte(8'h29);
    check_key("post_pause", 8'h29, 1'b1, 1'b0);

    // Reset after 5 bits discards the frame silently
    mark(); send_bits(mk_frame(8'h1C, 1'b0), 5, -1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (TO + 10) @(negedge clk);
    check_eq("rstmid_strobes", 32'(n_str - s0), 32'd0);
    check_eq("rstmid_errs", 32'(n_ferr - e0), 32'd0);
    check_eq("rstmid_code", 32'(kbd.key_code), 32'd0);
    mark(); send_byte(8'h1C);
    check_key("post_rst", 8'h1C, 1'b1, 1'b0);

    check_eq("no_double_pulse", 32'(n_dbl), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
